// File: rtl/hwpf_mstack.sv
// rtl/hwpf_mstack.sv - multi-channel LIFO prefetch stack with round-robin issue and drop-oldest overflow
// Optional feature: define HWPF_MSTACK_DEDUP_EN to discard pushes equal to the target channel's current top.
module hwpf_mstack #(
    parameter int LANE_SIZE   = 64,
    parameter int STACK_DEPTH = 8,
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 40,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              lock_i,
    input  logic              push_i,
    input  logic [CH_W-1:0]   push_ch_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [CH_W-1:0]   req_ch_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              drop_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LANE_SIZE - 1));
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(STACK_DEPTH);

    // Each channel is a ring: base_q marks the oldest slot, top = base + count - 1.
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [PTR_W-1:0]  base_q [NUM_CH];
    logic [PTR_W-1:0]  base_d [NUM_CH];
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] mem_q  [NUM_CH][STACK_DEPTH];

    logic [PTR_W-1:0]  top_idx [NUM_CH];
    logic [NUM_CH-1:0] nonempty;
    logic              any_valid;
    logic [CH_W-1:0]   sel;
    logic              found;
    logic [ADDR_W-1:0] top_addr;

    logic              push_ok;
    logic [CH_W-1:0]   pch;
    logic [ADDR_W-1:0] aligned;
    logic              dup;
    logic              do_push;
    logic              do_pop;

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [PTR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_data;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            top_idx[c]  = base_q[c] + PTR_W'(cnt_q[c] - 1'b1);
            nonempty[c] = (cnt_q[c] != '0);
        end
    end

    // Round-robin pick: first non-empty channel at or after rr_q.
    always_comb begin
        int idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
    end

    assign any_valid   = |nonempty;
    assign top_addr    = mem_q[sel][top_idx[sel]];
    assign req_valid_o = any_valid & ~lock_i;
    assign req_ch_o    = sel;
    assign req_addr_o  = any_valid ? top_addr : '0;
    assign empty_o     = ~any_valid;
    assign drop_o      = drop_q;

    assign push_ok = push_i && (int'(push_ch_i) < NUM_CH);
    assign pch     = push_ok ? push_ch_i : '0;
    assign aligned = push_addr_i & ALIGN_MASK;

`ifdef HWPF_MSTACK_DEDUP_EN
    assign dup = nonempty[pch] && (mem_q[pch][top_idx[pch]] == aligned);
`else
    assign dup = 1'b0;
`endif

    assign do_push = push_ok && !dup && !lock_i && !flush_i;
    assign do_pop  = req_valid_o && req_ready_i && !flush_i;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c]  = cnt_q[c];
            base_d[c] = base_q[c];
        end
        rr_d    = rr_q;
        drop_d  = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = pch;
        wr_idx  = '0;
        wr_data = aligned;

        if (flush_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_d[c] = '0;
            end
            rr_d = '0;
        end else begin
            if (do_pop) begin
                rr_d = CH_W'((int'(sel) + 1) % NUM_CH);
            end
            if (do_push && do_pop && (pch == sel)) begin
                // Push replaces the entry being popped; depth is unchanged.
                wr_en  = 1'b1;
                wr_idx = top_idx[pch];
            end else begin
                if (do_pop) begin
                    cnt_d[sel] = cnt_q[sel] - 1'b1;
                end
                if (do_push) begin
                    wr_en = 1'b1;
                    if (cnt_q[pch] == FULL_CNT) begin
                        // Oldest slot becomes the newest; advancing base discards it.
                        wr_idx      = base_q[pch];
                        base_d[pch] = base_q[pch] + 1'b1;
                        drop_d      = 1'b1;
                    end else begin
                        wr_idx     = base_q[pch] + PTR_W'(cnt_q[pch]);
                        cnt_d[pch] = cnt_q[pch] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]  <= '0;
                base_q[c] <= '0;
            end
            rr_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]  <= cnt_d[c];
                base_q[c] <= base_d[c];
            end
            rr_q   <= rr_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ch][wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_hwpf_mstack.sv
// tb/tb_hwpf_mstack.sv - queue-model self-checking bench for hwpf_mstack (2 channels, depth 4, 64B lines)
module tb_hwpf_mstack;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        lock_i = 1'b0;
    logic        push_i = 1'b0;
    logic [0:0]  push_ch_i = 1'b0;
    logic [39:0] push_addr_i = '0;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [0:0]  req_ch_o;
    logic [39:0] req_addr_o;
    logic        drop_o;
    logic        empty_o;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Reference model: newest entry at the back of each queue.
    logic [39:0] mq [2][$];
    int          rr_m = 0;
    bit          drop_m = 1'b0;

    hwpf_mstack #(
        .LANE_SIZE(64), .STACK_DEPTH(4), .NUM_CH(2), .ADDR_W(40)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .lock_i(lock_i),
        .push_i(push_i), .push_ch_i(push_ch_i), .push_addr_i(push_addr_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_ch_o(req_ch_o),
        .req_addr_o(req_addr_o), .drop_o(drop_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int model_sel();
        for (int i = 0; i < 2; i++) begin
            int c;
            c = (rr_m + i) % 2;
            if (mq[c].size() > 0) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input bit fl, input bit lk, input bit ps, input bit pc,
                              input logic [39:0] pa, input bit rd);
        int s;
        bit pop, dup, pu;
        logic [39:0] al;
        s = model_sel();
        drop_m = 1'b0;
        al = pa & ~40'h3F;
        if (fl) begin
            mq[0].delete();
            mq[1].delete();
            rr_m = 0;
        end else if (!lk) begin
            pop = (s >= 0) && rd;
            dup = 1'b0;
`ifdef HWPF_MSTACK_DEDUP_EN
            dup = (mq[int'(pc)].size() > 0) && (mq[int'(pc)][mq[int'(pc)].size()-1] == al);
`endif
            pu = ps && !dup;
            if (pop) rr_m = (s + 1) % 2;
            if (pu && pop && int'(pc) == s) begin
                mq[s][mq[s].size()-1] = al;
            end else begin
                if (pop) void'(mq[s].pop_back());
                if (pu) begin
                    if (mq[int'(pc)].size() == 4) begin
                        void'(mq[int'(pc)].pop_front());
                        drop_m = 1'b1;
                    end
                    mq[int'(pc)].push_back(al);
                end
            end
        end
    endtask

    // Per-cycle comparison mid-cycle, against the model's view of current state.
    always @(negedge clk_i) begin
        if (chk_en) begin
            int s;
            s = model_sel();
            check("req_valid", {63'b0, req_valid_o}, {63'b0, (s >= 0) && !lock_i});
            check("empty", {63'b0, empty_o}, {63'b0, s < 0});
            check("drop", {63'b0, drop_o}, {63'b0, drop_m});
            check("req_ch", {63'b0, req_ch_o}, (s >= 0) ? 64'(s) : 64'd0);
            check("req_addr", {24'b0, req_addr_o}, (s >= 0) ? {24'b0, mq[s][mq[s].size()-1]} : 64'd0);
        end
    end

    task automatic drive(input bit fl, input bit lk, input bit ps, input bit pc,
                         input logic [39:0] pa, input bit rd);
        flush_i = fl; lock_i = lk; push_i = ps; push_ch_i = pc;
        push_addr_i = pa; req_ready_i = rd;
        @(posedge clk_i);
        #1;
        model_step(fl, lk, ps, pc, pa, rd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {63'b0, req_valid_o}, 64'd0);
        check({tag, "_drop"},  {63'b0, drop_o},      64'd0);
        check({tag, "_empty"}, {63'b0, empty_o},     64'd1);
        check({tag, "_ch"},    {63'b0, req_ch_o},    64'd0);
        check({tag, "_addr"},  {24'b0, req_addr_o},  64'd0);
    endtask

    logic [39:0] exp39 [4] = '{40'h200, 40'h1C0, 40'h180, 40'h140};
    logic [39:0] pool  [4] = '{40'h1000, 40'h1010, 40'h2040, 40'h3FC0};
    bit          exp40 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("por");
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Push two to ch0, then drain newest first.
        drive(0, 0, 1, 0, 40'h1008, 0);
        drive(0, 0, 1, 0, 40'h2010, 0);
        check("t1_valid", {63'b0, req_valid_o}, 64'd1);
        check("t1_addr0", {24'b0, req_addr_o}, 64'h2000);
        drive(0, 0, 0, 0, 40'h0, 1);
        check("t1_addr1", {24'b0, req_addr_o}, 64'h1000);
        drive(0, 0, 0, 0, 40'h0, 1);
        check("t1_valid_end", {63'b0, req_valid_o}, 64'd0);
        check("t1_empty_end", {63'b0, empty_o}, 64'd1);

        // Overflow ch1: fifth push discards the oldest.
        drive(0, 0, 1, 1, 40'h100, 0);
        drive(0, 0, 1, 1, 40'h140, 0);
        drive(0, 0, 1, 1, 40'h180, 0);
        drive(0, 0, 1, 1, 40'h1C0, 0);
        check("t2_drop4", {63'b0, drop_o}, 64'd0);
        drive(0, 0, 1, 1, 40'h200, 0);
        check("t2_drop5", {63'b0, drop_o}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t2_pop_addr", {24'b0, req_addr_o}, {24'b0, exp39[i]});
            drive(0, 0, 0, 0, 40'h0, 1);
        end
        check("t2_empty", {63'b0, empty_o}, 64'd1);

        // Round-robin alternation.
        drive(0, 0, 1, 0, 40'h400, 0);
        drive(0, 0, 1, 0, 40'h440, 0);
        drive(0, 0, 1, 1, 40'h800, 0);
        drive(0, 0, 1, 1, 40'h840, 0);
        for (int i = 0; i < 4; i++) begin
            check("t3_rr_ch", {63'b0, req_ch_o}, {63'b0, exp40[i]});
            drive(0, 0, 0, 0, 40'h0, 1);
        end

        // Push and pop on the same channel overwrites the top.
        drive(0, 0, 1, 0, 40'h40, 0);
        drive(0, 0, 1, 0, 40'h80, 1);
        check("t4_addr", {24'b0, req_addr_o}, 64'h80);
        drive(0, 0, 0, 0, 40'h0, 1);
        check("t4_empty", {63'b0, empty_o}, 64'd1);

        // Lock freezes; flush wins over lock.
        drive(0, 0, 1, 0, 40'h300, 0);
        drive(0, 1, 1, 1, 40'h500, 1);
        check("t5_lock_valid", {63'b0, req_valid_o}, 64'd0);
        check("t5_lock_empty", {63'b0, empty_o}, 64'd0);
        drive(0, 0, 0, 0, 40'h0, 0);
        check("t5_unlock_addr", {24'b0, req_addr_o}, 64'h300);
        check("t5_unlock_ch", {63'b0, req_ch_o}, 64'd0);
        drive(1, 1, 1, 1, 40'h600, 1);
        check("t5_flush_empty", {63'b0, empty_o}, 64'd1);
        check("t5_flush_drop", {63'b0, drop_o}, 64'd0);

        // Duplicate pushes.
        drive(0, 0, 1, 0, 40'h1000, 0);
        drive(0, 0, 1, 0, 40'h1000, 0);
        drive(0, 0, 0, 0, 40'h0, 1);
`ifdef HWPF_MSTACK_DEDUP_EN
        check("t6_dedup_empty", {63'b0, empty_o}, 64'd1);
`else
        check("t6_dedup_empty", {63'b0, empty_o}, 64'd0);
`endif
        drive(1, 0, 0, 0, 40'h0, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [39:0] a;
            a = ($urandom % 4 == 0) ? pool[$urandom % 4] : {$urandom, $urandom} ;
            drive(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 3) != 0,
                  1'($urandom), a, 1'($urandom));
        end

        // Reset asserted mid-operation with a handshake in flight.
        drive(0, 0, 1, 1, 40'hABC0, 0);
        drive(0, 0, 1, 0, 40'hDEF0, 0);
        chk_en = 1'b0;
        push_i = 1'b1; req_ready_i = 1'b1; lock_i = 1'b0; flush_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid");
        mq[0].delete();
        mq[1].delete();
        rr_m = 0;
        drop_m = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("hold");
        push_i = 1'b0; req_ready_i = 1'b0;
        rst_ni = 1'b1;
        chk_en = 1'b1;
        drive(0, 0, 1, 1, 40'h7FF, 0);
        check("post_rst_addr", {24'b0, req_addr_o}, 64'h7C0);
        check("post_rst_ch", {63'b0, req_ch_o}, 64'd1);
        drive(0, 0, 0, 0, 40'h0, 1);
        check("post_rst_empty", {63'b0, empty_o}, 64'd1);

        @(posedge clk_i);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hwpf_mstack.md
HWPF_MSTACK -- requirements
Module: hwpf_mstack

Interface
REQ-001 SHALL have parameter LANE_SIZE, default 64: cache line size in bytes, power of two.
REQ-002 SHALL have parameter STACK_DEPTH, default 8: entries per channel, power of two, >=2.
REQ-003 SHALL have parameter NUM_CH, default 4: independent LIFO channels, >=1.
REQ-004 SHALL have parameter ADDR_W, default 40: address width in bits.
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush_i  in  1  empty all channels.
REQ-008 SHALL have port lock_i  in  1  freeze all state and suppress issue.
REQ-009 SHALL have port push_i  in  1  push request.
REQ-010 SHALL have port push_ch_i  in  max(1,$clog2(NUM_CH))  target channel of the push.
REQ-011 SHALL have port push_addr_i  in  ADDR_W  address to push.
REQ-012 SHALL have port req_valid_o  out  1  a prefetch request is offered.
REQ-013 SHALL have port req_ready_i  in  1  consumer accepts the offered request.
REQ-014 SHALL have port req_ch_o  out  max(1,$clog2(NUM_CH))  channel of the offered request.
REQ-015 SHALL have port req_addr_o  out  ADDR_W  line-aligned address of the offered request.
REQ-016 SHALL have port drop_o  out  1  one-cycle pulse: oldest entry discarded by a push to a full channel.
REQ-017 SHALL have port empty_o  out  1  all channels empty.

Function
REQ-018 SHALL store push_addr_i with its low $clog2(LANE_SIZE) bits cleared.
REQ-019 SHALL keep a per-channel count, width $clog2(STACK_DEPTH+1), range 0..STACK_DEPTH; full means count==STACK_DEPTH.
REQ-020 SHALL offer the newest entry of the selected channel; req_valid_o = any channel non-empty AND !lock_i.
REQ-021 SHALL select the first non-empty channel at or after rr_ptr, wrapping modulo NUM_CH.
REQ-022 SHALL pop the offered entry on req_valid_o && req_ready_i, and set rr_ptr to (selected+1) mod NUM_CH.
REQ-023 SHALL hold req_ch_o and req_addr_o stable while req_valid_o && !req_ready_i and no push or flush occurs.
REQ-024 SHALL make a pushed entry visible on req_addr_o in the cycle after the push (1-cycle latency).
REQ-025 SHALL drop the oldest entry of a full channel on push, keep the count at STACK_DEPTH, and assert drop_o for one cycle.
REQ-026 SHALL implement drop-oldest by advancing a per-channel circular base pointer, with no data shifting.
REQ-027 SHALL, on push and pop to the same channel in one cycle, overwrite the top entry, leaving the count unchanged and drop_o low.
REQ-028 SHALL, on push and pop to different channels in one cycle, perform both independently.
REQ-029 SHALL, on flush_i, zero all counts and rr_ptr and hold drop_o low; flush_i has priority over lock_i, push and pop.
REQ-030 SHALL, on lock_i without flush_i, ignore push_i and req_ready_i and hold drop_o low.
REQ-031 SHALL ignore a push with push_ch_i >= NUM_CH.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously clear all counts, base pointers and rr_ptr.
REQ-033 SHALL drive req_valid_o=0, drop_o=0, empty_o=1, req_ch_o=0 and req_addr_o=0 while in reset.
REQ-034 SHALL leave storage contents undefined after reset; empty channels never expose them.
REQ-035 SHALL discard any in-flight handshake when reset asserts mid-operation.

Configuration
REQ-036 SHALL, with HWPF_MSTACK_DEDUP_EN defined, discard a push whose aligned address equals the current top of the target channel; count and drop_o are unaffected.
REQ-037 SHALL, without HWPF_MSTACK_DEDUP_EN, accept every valid push, including duplicates.

Verification (NUM_CH=2, STACK_DEPTH=4, LANE_SIZE=64)
REQ-038 SHALL cover: push ch0 0x1008 then 0x2010 with ready=1 -> issues 0x2000 then 0x1000, then req_valid_o=0 and empty_o=1.
REQ-039 SHALL cover: push ch1 0x100,0x140,0x180,0x1C0,0x200 -> drop_o pulses on the 5th push; the pops return 0x200,0x1C0,0x180,0x140.
REQ-040 SHALL cover: ch0 and ch1 each hold 2 entries, ready=1 -> req_ch_o sequence 0,1,0,1.
REQ-041 SHALL cover: ch0 top 0x40, push ch0 0x80 while popping ch0 -> count unchanged, next offer is 0x80.
REQ-042 SHALL cover: lock_i=1 with push and ready asserted -> no state change and req_valid_o=0; then flush_i=1 -> empty_o=1 next cycle.
REQ-043 SHALL cover, with DEDUP enabled: push ch0 0x1000 twice -> count=1; with DEDUP disabled -> count=2.
